// File: rtl/threshold2_udiv_seq.sv
// rtl/threshold2_udiv_seq.sv - radix-2 restoring sequential unsigned divider for the threshold2 path
//
// Recovers a normalised value from a scaled pixel-statistic product (e.g. sum/count).
// The divider produces one quotient bit per enabled cycle. It uses a valid/ready
// handshake on both the operand side and the result side.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; takes priority over ce
//   ce         in   clock enable; low freezes all state and outputs
//   in_valid   in   dividend/divisor pair is valid
//   in_ready   out  divider is idle and can accept an operand pair
//   dividend   in   unsigned dividend  [DIVIDEND_WIDTH]
//   divisor    in   unsigned divisor   [DIVISOR_WIDTH]
//   out_valid  out  result is valid
//   out_ready  in   consumer accepts the result
//   quotient   out  unsigned quotient  [DIVIDEND_WIDTH]
//   remainder  out  unsigned remainder [DIVISOR_WIDTH]
//   div_zero   out  result came from a zero divisor

module threshold2_udiv_seq #(
    parameter int DIVIDEND_WIDTH = 21,
    parameter int DIVISOR_WIDTH  = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_zero
);

    localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    // work_q starts as the dividend. Each step shifts its MSB out into the
    // partial remainder and shifts the new quotient bit in at the LSB. After
    // DIVIDEND_WIDTH steps, it holds the quotient.
    logic [DIVIDEND_WIDTH-1:0] work_q;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [DIVIDEND_WIDTH-1:0] quotient_q;
    logic [DIVISOR_WIDTH-1:0]  remainder_q;
    logic                      div_zero_q;

    logic [DIVISOR_WIDTH:0]    trial;
    logic                      fits;
    logic [DIVISOR_WIDTH-1:0]  diff;
    logic [DIVISOR_WIDTH-1:0]  rem_d;
    logic [DIVIDEND_WIDTH-1:0] work_d;

    // One restoring step. When the trial value fits, the true difference is
    // smaller than the divisor. That means the low DIVISOR_WIDTH bits of the
    // modular subtraction are exact.
    always_comb begin
        trial  = {rem_q, work_q[DIVIDEND_WIDTH-1]};
        fits   = (trial >= {1'b0, dvs_q});
        diff   = trial[DIVISOR_WIDTH-1:0] - dvs_q;
        rem_d  = fits ? diff : trial[DIVISOR_WIDTH-1:0];
        work_d = {work_q[DIVIDEND_WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dvs_q      <= divisor;
                        work_q     <= dividend;
                        rem_q      <= '0;
                        div_zero_q <= (divisor == '0);
                        if (divisor == '0) begin
                            // A zero divisor skips the iteration entirely.
                            quotient_q  <= '1;
                            remainder_q <= dividend[DIVISOR_WIDTH-1:0];
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        // The published result only changes here. While a
                        // division runs, the previous result stays visible.
                        quotient_q  <= work_d;
                        remainder_q <= rem_d;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Return to IDLE only; a new accept needs a separate cycle.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_threshold2_udiv_seq.sv
// tb/tb_threshold2_udiv_seq.sv - directed and randomised self-checking bench for threshold2_udiv_seq

module tb_threshold2_udiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] dividend;
    logic [13:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] quotient;
    logic [13:0] remainder;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    threshold2_udiv_seq #(.DIVIDEND_WIDTH(21), .DIVISOR_WIDTH(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Present one operand pair at a negedge with the DUT idle, then wait for
    // out_valid. lat counts posedges after the accept edge. The result is
    // taken with a one-cycle out_ready pulse.
    task automatic run_div(input logic [20:0] a, input logic [13:0] b,
                           output logic [20:0] q, output logic [13:0] r,
                           output logic dz, output int lat, output bit to);
        in_valid = 1'b1; dividend = a; divisor = b; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        to = !out_valid;
        q = quotient; r = remainder; dz = div_zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (quotient !== 21'd0 || remainder !== 14'd0 || div_zero !== 1'b0) begin
            fails++; $display("FAIL reset_result got q=%0d r=%0d dz=%b exp 0/0/0", quotient, remainder, div_zero);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [20:0] q; logic [13:0] r; logic dz; int lat; bit to;
        run_div(21'd1000000, 14'd300, q, r, dz, lat, to);
        tests++; if (to || q !== 21'd3333 || r !== 14'd100 || dz !== 1'b0) begin
            fails++; $display("FAIL basic_1000000_300 got q=%0d r=%0d dz=%b to=%0d exp q=3333 r=100 dz=0", q, r, dz, to);
        end
        tests++; if (lat !== 21) begin fails++; $display("FAIL basic_latency got=%0d exp=21", lat); end
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_back_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [20:0] q; logic [13:0] r; logic dz; int lat; bit to;
        run_div(21'd2097151, 14'd1, q, r, dz, lat, to);
        tests++; if (to || q !== 21'd2097151 || r !== 14'd0 || dz !== 1'b0) begin
            fails++; $display("FAIL max_div1 got q=%0d r=%0d dz=%b exp q=2097151 r=0 dz=0", q, r, dz);
        end
        run_div(21'd5, 14'd16383, q, r, dz, lat, to);
        tests++; if (to || q !== 21'd0 || r !== 14'd5 || dz !== 1'b0) begin
            fails++; $display("FAIL small_by_max got q=%0d r=%0d dz=%b exp q=0 r=5 dz=0", q, r, dz);
        end
        run_div(21'd2097151, 14'd16383, q, r, dz, lat, to);
        tests++; if (to || q !== 21'd128 || r !== 14'd127 || dz !== 1'b0) begin
            fails++; $display("FAIL max_by_max got q=%0d r=%0d dz=%b exp q=128 r=127 dz=0", q, r, dz);
        end
    endtask

    task automatic test_div_zero();
        logic [20:0] q; logic [13:0] r; logic dz; int lat; bit to;
        run_div(21'd1234, 14'd0, q, r, dz, lat, to);
        tests++; if (to || lat !== 0) begin fails++; $display("FAIL divzero_latency got=%0d exp=0 edges after accept", lat); end
        tests++; if (q !== 21'h1FFFFF || r !== 14'd1234 || dz !== 1'b1) begin
            fails++; $display("FAIL divzero_result got q=%h r=%0d dz=%b exp q=1fffff r=1234 dz=1", q, r, dz);
        end
        // div_zero must clear on the next accept, while the old result stays visible during BUSY.
        in_valid = 1'b1; dividend = 21'd100; divisor = 14'd7;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        tests++; if (div_zero !== 1'b0 || quotient !== 21'h1FFFFF || remainder !== 14'd1234) begin
            fails++; $display("FAIL divzero_clear got dz=%b q=%h r=%0d exp dz=0 q=1fffff r=1234", div_zero, quotient, remainder);
        end
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        tests++; if (out_valid !== 1'b1 || quotient !== 21'd14 || remainder !== 14'd2) begin
            fails++; $display("FAIL after_divzero got v=%b q=%0d r=%0d exp v=1 q=14 r=2", out_valid, quotient, remainder);
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int i;
        bit stable;
        in_valid = 1'b1; dividend = 21'd999; divisor = 14'd10; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_reach_done got out_valid=%b exp=1", out_valid); end
        // Offer a different operand pair while in DONE; it must be ignored.
        in_valid = 1'b1; dividend = 21'd5; divisor = 14'd0;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 21'd99 ||
                remainder !== 14'd9 || div_zero !== 1'b0) stable = 1'b0;
        end
        tests++; if (!stable) begin
            fails++; $display("FAIL bp_hold got v=%b rdy=%b q=%0d r=%0d dz=%b exp v=1 rdy=0 q=99 r=9 dz=0",
                              out_valid, in_ready, quotient, remainder, div_zero);
        end
        // ce low in DONE with out_ready high: handshake must not complete.
        in_valid = 1'b0; ce = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_ce_hold got out_valid=%b exp=1", out_valid); end
        // Release with in_valid high: next cycle is IDLE, not an immediate accept.
        ce = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        // That pair (divisor 0) is accepted on this edge and goes straight to DONE.
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || div_zero !== 1'b1 || remainder !== 14'd5) begin
            fails++; $display("FAIL bp_next_accept got v=%b dz=%b r=%0d exp v=1 dz=1 r=5", out_valid, div_zero, remainder);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit stale;
        in_valid = 1'b1; dividend = 21'd1000000; divisor = 14'd300;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 21'd0 || remainder !== 14'd0) begin
            fails++; $display("FAIL abort_state got rdy=%b v=%b q=%0d r=%0d exp 1/0/0/0", in_ready, out_valid, quotient, remainder);
        end
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
        end
        out_ready = 1'b0;
        tests++; if (stale) begin fails++; $display("FAIL abort_no_stale got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_ce_stall();
        int lat;
        bit held;
        // ce low in IDLE: an offered pair is not accepted.
        ce = 1'b0; in_valid = 1'b1; dividend = 21'd77; divisor = 14'd0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; ce = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL ce_idle_no_accept got rdy=%b v=%b exp 1/0", in_ready, out_valid);
        end
        in_valid = 1'b1; dividend = 21'd1000000; divisor = 14'd300; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        repeat (5) begin @(negedge clk); lat++; end
        ce = 1'b0;
        held = 1'b1;
        repeat (5) begin
            @(negedge clk); lat++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) held = 1'b0;
        end
        ce = 1'b1;
        tests++; if (!held) begin fails++; $display("FAIL ce_busy_hold got rdy=%b v=%b exp 0/0", in_ready, out_valid); end
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        tests++; if (lat !== 26 || quotient !== 21'd3333 || remainder !== 14'd100) begin
            fails++; $display("FAIL ce_latency got lat=%0d q=%0d r=%0d exp lat=26 q=3333 r=100", lat, quotient, remainder);
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [20:0] a, q, eq; logic [13:0] b, r, er; logic dz; int lat; bit to;
        int bad = 0;
        for (int n = 0; n < 2000; n++) begin
            a = 21'($urandom) >> $urandom_range(0, 20);
            b = 14'($urandom) >> $urandom_range(0, 13);
            if ($urandom_range(0, 49) == 0) b = '0;
            if (b == '0) begin
                eq = '1; er = a[13:0];
            end else begin
                eq = a / 21'(b); er = 14'(a % 21'(b));
            end
            run_div(a, b, q, r, dz, lat, to);
            tests++;
            if (to || q !== eq || r !== er || dz !== (b == '0) || lat !== ((b == '0) ? 0 : 21)) begin
                fails++; bad++;
                if (bad <= 5)
                    $display("FAIL random a=%0d b=%0d got q=%0d r=%0d dz=%b lat=%0d exp q=%0d r=%0d",
                             a, b, q, r, dz, lat, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_backpressure();
        test_reset_abort();
        test_ce_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
